// File: rtl/cp0_irq_timer_pkg.sv
// Shared CP0 constants: cause codes, register numbers, SR/Cause field positions
// and the per-cycle exception/ERET event decode type.
package cp0_irq_timer_pkg;

  localparam logic [4:0] CAUSE_INT  = 5'd0;
  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;
  localparam logic [4:0] CAUSE_ERET = 5'd31;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO = 8;
  localparam int CAUSE_TI    = 30;
  localparam int CAUSE_BD    = 31;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_ERET = 2'd2
  } cp0Event_e;

  function automatic logic [31:0] packSr(input logic [7:0] im, input logic exl, input logic ie);
    packSr = {16'd0, im, 6'd0, exl, ie};
  endfunction

  function automatic logic [31:0] packCause(input logic bd, input logic ti,
                                            input logic [7:0] ip, input logic [4:0] exc);
    packCause = {bd, ti, 14'd0, ip, 1'b0, exc, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_irq_timer_if.sv
// Pipeline <-> CP0 bundle: MTC0/MFC0 access, exception events, interrupt lines
// and the fetch redirect. master = pipeline side, slave = CP0.
interface cp0_irq_timer_if #(
  parameter int NUM_EXT_IRQ = 5
);
  logic                   we;
  logic [4:0]             addr;
  logic [31:0]            wdata;
  logic [31:0]            rdata;
  logic                   has_exception_in_pipeline;
  logic                   is_exception;
  logic [4:0]             exc_cause;
  logic                   is_bd;
  logic [31:0]            exc_pc;
  logic [31:0]            bad_vaddr;
  logic [NUM_EXT_IRQ-1:0] ext_irq;
  logic                   jump;
  logic [31:0]            jump_address;
  logic                   interrupt_now;
  logic                   timer_irq;

  modport master (
    output we, addr, wdata, has_exception_in_pipeline, is_exception, exc_cause,
           is_bd, exc_pc, bad_vaddr, ext_irq,
    input  rdata, jump, jump_address, interrupt_now, timer_irq
  );

  modport slave (
    input  we, addr, wdata, has_exception_in_pipeline, is_exception, exc_cause,
           is_bd, exc_pc, bad_vaddr, ext_irq,
    output rdata, jump, jump_address, interrupt_now, timer_irq
  );
endinterface

// File: rtl/cp0_irq_timer_irq_sync.sv
// Multi-flop synchroniser for asynchronous level interrupt requests.
module irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stageQ [STAGES];

  // Shift chain; stage 0 is the only flop that sees the asynchronous input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stageQ[i] <= '0;
      end
    end else begin
      stageQ[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stageQ[i] <= stageQ[i-1];
      end
    end
  end

  assign q = stageQ[STAGES-1];

endmodule

// File: rtl/cp0_irq_timer.sv
// Coprocessor 0: SR/Cause/EPC/PrId/BadVAddr, Count/Compare timer, interrupt
// qualification and exception/ERET redirect for the fetch stage.
module cp0_irq_timer
  import cp0_irq_timer_pkg::*;
#(
  parameter int          NUM_EXT_IRQ = 5,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'h00004180,
  parameter logic [31:0] PRID_VALUE  = 32'hDEADBEEF,
  parameter int          TIMER_EN    = 1
) (
  input logic             clk,
  input logic             reset_n,
  cp0_irq_timer_if.slave  bus
);

  logic [7:0]             srIm;
  logic                   srExl;
  logic                   srIe;
  logic                   causeBd;
  logic                   causeTi;
  logic [1:0]             causeSw;
  logic [4:0]             causeExc;
  logic [31:0]            epcReg;
  logic [31:0]            badVaddrReg;
  logic [31:0]            countReg;
  logic [31:0]            compareReg;
  logic [NUM_EXT_IRQ-1:0] extSync;
  logic [7:0]             ipVec;
  logic [31:0]            countNext;
  logic                   timerMatch;
  cp0Event_e              evt;

  irq_sync #(
    .WIDTH  (NUM_EXT_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.ext_irq),
    .q       (extSync)
  );

  // Pending-interrupt vector: software bits, synchronised lines, timer on IP7
  always_comb begin
    ipVec      = 8'd0;
    ipVec[1:0] = causeSw;
    for (int i = 0; i < NUM_EXT_IRQ; i++) begin
      ipVec[2+i] = extSync[i];
    end
    ipVec[7] = causeTi;
  end

  // Classify this cycle's exception input; illegal combinations are dropped
  always_comb begin
    if (bus.is_exception && !srExl && (bus.exc_cause != CAUSE_ERET)) begin
      evt = EV_EXC;
    end else if (bus.is_exception && srExl && (bus.exc_cause == CAUSE_ERET)) begin
      evt = EV_ERET;
    end else begin
      evt = EV_NONE;
    end
  end

  // Next Count value; an MTC0 Count replaces the increment
  always_comb begin
    if (TIMER_EN == 0) begin
      countNext  = 32'd0;
      timerMatch = 1'b0;
    end else begin
      if (bus.we && (bus.addr == CP0_COUNT)) begin
        countNext = bus.wdata;
      end else begin
        countNext = countReg + 32'd1;
      end
      timerMatch = (countNext == compareReg);
    end
  end

  // Redirect and interrupt decision go straight to fetch in the same cycle
  always_comb begin
    case (evt)
      EV_EXC: begin
        bus.jump         = 1'b1;
        bus.jump_address = EXC_VECTOR;
      end
      EV_ERET: begin
        bus.jump         = 1'b1;
        bus.jump_address = epcReg;
      end
      default: begin
        bus.jump         = 1'b0;
        bus.jump_address = 32'd0;
      end
    endcase
    bus.interrupt_now = srIe && !srExl && !bus.has_exception_in_pipeline && ((ipVec & srIm) != 8'd0);
    bus.timer_irq     = causeTi;
  end

  // MFC0 read mux
  always_comb begin
    case (bus.addr)
      CP0_BADVADDR: bus.rdata = badVaddrReg;
      CP0_COUNT:    bus.rdata = countReg;
      CP0_COMPARE:  bus.rdata = compareReg;
      CP0_SR:       bus.rdata = packSr(srIm, srExl, srIe);
      CP0_CAUSE:    bus.rdata = packCause(causeBd, causeTi, ipVec, causeExc);
      CP0_EPC:      bus.rdata = epcReg;
      CP0_PRID:     bus.rdata = PRID_VALUE;
      default:      bus.rdata = 32'd0;
    endcase
  end

  // Architectural state; exception/ERET updates are applied after MTC0 so they win
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srIm        <= 8'hFF;
      srExl       <= 1'b1;
      srIe        <= 1'b0;
      causeBd     <= 1'b0;
      causeTi     <= 1'b0;
      causeSw     <= 2'b00;
      causeExc    <= 5'd0;
      epcReg      <= 32'd0;
      badVaddrReg <= 32'd0;
      countReg    <= 32'd0;
      compareReg  <= 32'd0;
    end else begin
      countReg <= countNext;
      if (bus.we && (bus.addr == CP0_COMPARE)) begin
        compareReg <= bus.wdata;
        causeTi    <= 1'b0;
      end else if (timerMatch) begin
        causeTi <= 1'b1;
      end else begin
        causeTi <= causeTi;
      end
      if (bus.we) begin
        case (bus.addr)
          CP0_SR: begin
            srIm  <= bus.wdata[SR_IM_LO +: 8];
            srExl <= bus.wdata[SR_EXL];
            srIe  <= bus.wdata[SR_IE];
          end
          CP0_CAUSE: causeSw <= bus.wdata[CAUSE_IP_LO +: 2];
          CP0_EPC:   epcReg  <= bus.wdata;
          default:   ;
        endcase
      end
      case (evt)
        EV_EXC: begin
          srExl    <= 1'b1;
          causeBd  <= bus.is_bd;
          causeExc <= bus.exc_cause;
          epcReg   <= bus.is_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
          if ((bus.exc_cause == CAUSE_ADEL) || (bus.exc_cause == CAUSE_ADES)) begin
            badVaddrReg <= bus.bad_vaddr;
          end
        end
        EV_ERET: srExl <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
